// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a carry flip-flop and three
// shift registers. The operands are captured on start and added LSB first, one bit per clock.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a request that is honoured only while busy=0. Starts
  // are not queued. done is a one-cycle result-valid pulse with no back-pressure.
  // sum and cout hold their value until the next done.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             c_ff;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry;

  // Shared full-adder cell plus the sum shift value. The shift-then-set form
  // also covers WIDTH=1, where there are no upper bits to slice.
  always_comb begin
    sum_bit = a_sh[0] ^ b_sh[0] ^ c_ff;
    carry   = (a_sh[0] & b_sh[0]) | (c_ff & (a_sh[0] ^ b_sh[0]));
    s_next  = s_sh >> 1;
    s_next[WIDTH-1] = sum_bit;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c_ff  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c_ff  <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c_ff <= carry;
          s_sh <= s_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= s_next;
            cout  <= carry;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
